// File: rtl/pll_drp_ctrl.sv
// DRP read-modify-write sequencer for a PLLE2_ADV/MMCM: buffers (addr, mask, data) entries,
// applies them under PLL reset, then waits for lock. Optional watchdog: PLL_DRP_CTRL_WATCHDOG_EN.
module pll_drp_ctrl #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                       dclk,
    input  logic                       rst_n,
    input  logic                       load_en,
    input  logic [6:0]                 load_addr,
    input  logic [15:0]                load_mask,
    input  logic [15:0]                load_data,
    input  logic                       clr,
    input  logic                       start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [6:0]                 daddr,
    output logic                       den,
    output logic                       dwe,
    output logic [15:0]                di,
    input  logic [15:0]                drp_do,
    input  logic                       drdy,
    output logic                       pll_rst,
    input  logic                       locked
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned EW = 39;

`ifdef PLL_DRP_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ASSERT_RST = 4'd1;
    localparam logic [3:0] S_RD         = 4'd2;
    localparam logic [3:0] S_RD_WAIT    = 4'd3;
    localparam logic [3:0] S_WR         = 4'd4;
    localparam logic [3:0] S_WR_WAIT    = 4'd5;
    localparam logic [3:0] S_RELEASE    = 4'd6;
    localparam logic [3:0] S_WAIT_LOCK  = 4'd7;
    localparam logic [3:0] S_FINISH     = 4'd8;

    logic [EW-1:0] entries [DEPTH];
    logic [3:0]    state, state_nxt;
    logic [IW-1:0] index, index_nxt;
    logic [CW-1:0] count_nxt;
    logic [WW-1:0] wd_cnt, wd_nxt;
    logic          start_q, start_q_nxt;
    logic          err_nxt, load_we, in_wait, timeout;
    logic [6:0]    daddr_nxt;
    logic [15:0]   di_nxt;
    logic          den_nxt, dwe_nxt, pll_rst_nxt, busy_nxt, done_nxt;
    logic [EW-1:0] entry;

    // Entry storage; emptiness is tracked by count alone
    always_ff @(posedge dclk) begin
        if (load_we) entries[count[IW-1:0]] <= {load_addr, load_mask, load_data};
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            index   <= '0;
            count   <= '0;
            wd_cnt  <= '0;
            start_q <= 1'b0;
            err     <= 1'b0;
            daddr   <= '0;
            di      <= '0;
            den     <= 1'b0;
            dwe     <= 1'b0;
            pll_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            index   <= index_nxt;
            count   <= count_nxt;
            wd_cnt  <= wd_nxt;
            start_q <= start_q_nxt;
            err     <= err_nxt;
            daddr   <= daddr_nxt;
            di      <= di_nxt;
            den     <= den_nxt;
            dwe     <= dwe_nxt;
            pll_rst <= pll_rst_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // START is registered so a same-cycle load lands in count before the sequence begins
    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        count_nxt   = count;
        err_nxt     = err;
        daddr_nxt   = daddr;
        di_nxt      = di;
        load_we     = 1'b0;
        start_q_nxt = start && (state == S_IDLE);
        in_wait     = (state == S_RD_WAIT) || (state == S_WR_WAIT) || (state == S_WAIT_LOCK);
        timeout     = WD_EN && in_wait && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

        case (state)
            S_IDLE: begin
                if (clr) begin
                    count_nxt = '0;
                end else if (load_en && (count != CW'(DEPTH))) begin
                    load_we   = 1'b1;
                    count_nxt = count + CW'(1);
                end
                if (start_q) begin
                    err_nxt   = 1'b0;
                    index_nxt = '0;
                    state_nxt = (count_nxt == '0) ? S_FINISH : S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: state_nxt = S_RD;
            S_RD:         state_nxt = S_RD_WAIT;
            S_RD_WAIT:    if (drdy) state_nxt = S_WR;
            S_WR:         state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drdy) begin
                    if (CW'(index) == count - CW'(1)) begin
                        state_nxt = S_RELEASE;
                    end else begin
                        index_nxt = index + IW'(1);
                        state_nxt = S_RD;
                    end
                end
            end
            S_RELEASE:    state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK:  if (locked) state_nxt = S_FINISH;
            S_FINISH:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase

        if (timeout) begin
            err_nxt   = 1'b1;
            state_nxt = S_FINISH;
        end

        entry = entries[index_nxt];
        if (state_nxt == S_RD) daddr_nxt = entry[38:32];
        if ((state == S_RD_WAIT) && (state_nxt == S_WR))
            di_nxt = (drp_do & entry[31:16]) | (entry[15:0] & ~entry[31:16]);

        wd_nxt      = (in_wait && (state_nxt == state)) ? wd_cnt + WW'(1) : '0;
        den_nxt     = (state_nxt == S_RD) || (state_nxt == S_WR);
        dwe_nxt     = (state_nxt == S_WR);
        pll_rst_nxt = (state_nxt == S_ASSERT_RST) || (state_nxt == S_RD) ||
                      (state_nxt == S_RD_WAIT) || (state_nxt == S_WR) || (state_nxt == S_WR_WAIT);
        busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
        done_nxt    = (state_nxt == S_FINISH);
    end

endmodule
